// File: rtl/cdc_gray_ptr_tx.sv
// rtl/cdc_gray_ptr_tx.sv - source-domain write pointer with registered Gray output for a CDC crossing
module cdc_gray_ptr_tx #(
   parameter int PTR_W = 4
) (
   input  logic             clk_a,
   input  logic             rst_n,
   input  logic             push_req,
   output logic             push_ack,
   input  logic [PTR_W-1:0] rd_gray_sync,
   output logic [PTR_W-1:0] wr_bin,
   output logic [PTR_W-1:0] wr_gray,
   output logic [PTR_W-1:0] level,
   output logic             full,
   output logic             empty
);

   localparam logic [PTR_W-1:0] DEPTH = {1'b1, {(PTR_W-1){1'b0}}};

   logic [PTR_W-1:0] wr_bin_q;
   logic [PTR_W-1:0] wr_gray_q;
   logic [PTR_W-1:0] rd_bin_q;
   logic [PTR_W-1:0] wr_bin_nxt;
   logic [PTR_W-1:0] rd_bin_d;

   assign wr_bin_nxt = wr_bin_q + PTR_W'(1);

   // Binary bit i is the XOR of all Gray bits from the MSB down to i.
   always_comb begin
      rd_bin_d = '0;
      for (int i = 0; i < PTR_W; i++) begin
         rd_bin_d[i] = ^(rd_gray_sync >> i);
      end
   end

   assign level    = wr_bin_q - rd_bin_q;
   assign full     = (level == DEPTH);
   assign empty    = (level == '0);
   assign push_ack = push_req & ~full;

   always_ff @(posedge clk_a or negedge rst_n) begin
      if (!rst_n) begin
         wr_bin_q  <= '0;
         wr_gray_q <= '0;
         rd_bin_q  <= '0;
      end else begin
         rd_bin_q <= rd_bin_d;
         if (push_ack) begin
            wr_bin_q  <= wr_bin_nxt;
            wr_gray_q <= wr_bin_nxt ^ (wr_bin_nxt >> 1);
         end
      end
   end

   // wr_gray is a bare flop output so the far-side synchronizer never sees a glitch.
   assign wr_bin  = wr_bin_q;
   assign wr_gray = wr_gray_q;

endmodule

// File: tb/tb_cdc_gray_ptr_tx.sv
// tb/tb_cdc_gray_ptr_tx.sv - directed self-checking bench for cdc_gray_ptr_tx
module tb_cdc_gray_ptr_tx;

   localparam int PTR_W = 4;

   logic             clk_a;
   logic             rst_n;
   logic             push_req;
   logic             push_ack;
   logic [PTR_W-1:0] rd_gray_sync;
   logic [PTR_W-1:0] wr_bin;
   logic [PTR_W-1:0] wr_gray;
   logic [PTR_W-1:0] level;
   logic             full;
   logic             empty;

   int n_checks = 0;
   int n_errors = 0;

   logic [PTR_W-1:0] gray_seq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                       4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   cdc_gray_ptr_tx #(.PTR_W(PTR_W)) dut (
      .clk_a       (clk_a),
      .rst_n       (rst_n),
      .push_req    (push_req),
      .push_ack    (push_ack),
      .rd_gray_sync(rd_gray_sync),
      .wr_bin      (wr_bin),
      .wr_gray     (wr_gray),
      .level       (level),
      .full        (full),
      .empty       (empty)
   );

   initial clk_a = 1'b0;
   always #5 clk_a = ~clk_a;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk_a);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr_bin"},  32'(wr_bin),  32'h0);
      check({tag, "_wr_gray"}, 32'(wr_gray), 32'h0);
      check({tag, "_level"},   32'(level),   32'h0);
      check({tag, "_full"},    32'(full),    32'h0);
      check({tag, "_empty"},   32'(empty),   32'h1);
      check({tag, "_ack"},     32'(push_ack), 32'h0);
   endtask

   task automatic do_reset();
      push_req     = 1'b0;
      rd_gray_sync = '0;
      rst_n        = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
   endtask

   logic [PTR_W-1:0] prev_gray;

   initial begin
      rst_n        = 1'b0;
      push_req     = 1'b0;
      rd_gray_sync = '0;
      #1;
      check_reset_outputs("rst_async");
      cycle();
      rst_n = 1'b1;
      cycle();
      cycle();
      check_reset_outputs("rst_idle");

      // 16 pushes with the far pointer tracking our own Gray code
      push_req = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         rd_gray_sync = wr_gray;
         prev_gray    = wr_gray;
         #1;
         check($sformatf("track_ack%0d", k), 32'(push_ack), 32'h1);
         cycle();
         check($sformatf("track_gray%0d", k), 32'(wr_gray), 32'(gray_seq[k % 16]));
         check($sformatf("track_ham%0d", k), 32'($countones(prev_gray ^ wr_gray)), 32'h1);
         check($sformatf("track_lvl%0d", k), 32'(level <= 4'd1), 32'h1);
      end
      push_req     = 1'b0;
      rd_gray_sync = wr_gray;
      cycle();
      check("track_wrap_bin", 32'(wr_bin), 32'h0);
      check("track_drain_lvl", 32'(level), 32'h0);
      check("track_drain_empty", 32'(empty), 32'h1);

      // Fill with a stalled reader
      do_reset();
      push_req = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         #1;
         check($sformatf("fill_ack%0d", k), 32'(push_ack), 32'h1);
         cycle();
         check($sformatf("fill_lvl%0d", k), 32'(level), 32'(k));
      end
      check("fill_full", 32'(full), 32'h1);
      check("fill_empty", 32'(empty), 32'h0);
      check("fill_ack9", 32'(push_ack), 32'h0);
      cycle();
      check("fill_hold_bin", 32'(wr_bin), 32'h8);
      check("fill_hold_gray", 32'(wr_gray), 32'hC);
      check("fill_hold_lvl", 32'(level), 32'h8);

      // Reader jumps to binary 2 (gray 3)
      push_req     = 1'b0;
      rd_gray_sync = 4'h3;
      #1;
      check("rel_full_before", 32'(full), 32'h1);
      cycle();
      check("rel_lvl", 32'(level), 32'h6);
      check("rel_full", 32'(full), 32'h0);
      push_req = 1'b1;
      #1;
      check("rel_ack", 32'(push_ack), 32'h1);
      cycle();
      check("rel_lvl_after", 32'(level), 32'h7);
      check("rel_bin_after", 32'(wr_bin), 32'h9);

      // Bring level to 5 (reader binary 4 = gray 6), then push with a reader jump of 3
      push_req     = 1'b0;
      rd_gray_sync = 4'h6;
      cycle();
      check("sim_lvl5", 32'(level), 32'h5);
      push_req     = 1'b1;
      rd_gray_sync = 4'h4;
      #1;
      check("sim_ack", 32'(push_ack), 32'h1);
      cycle();
      check("sim_lvl3", 32'(level), 32'h3);
      check("sim_bin", 32'(wr_bin), 32'hA);
      check("sim_gray", 32'(wr_gray), 32'hF);

      // Asynchronous reset mid-burst at wr_bin = 6
      do_reset();
      push_req = 1'b1;
      for (int k = 1; k <= 6; k++) cycle();
      check("mid_bin6", 32'(wr_bin), 32'h6);
      check("mid_gray6", 32'(wr_gray), 32'h5);
      #1;
      push_req = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      cycle();
      rst_n    = 1'b1;
      push_req = 1'b1;
      cycle();
      check("resume_gray", 32'(wr_gray), 32'h1);
      check("resume_bin", 32'(wr_bin), 32'h1);
      check("resume_lvl", 32'(level), 32'h1);
      push_req = 1'b0;
      cycle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
